midi_tx: RTL and testbench



---
 rtl/trivius_pkg.sv | 16 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/midi_tx.sv | 143 ++++++++++++++
 tb/tb_midi_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/trivius_pkg.sv
// Shared definitions for the trivius synth MIDI path: baud constants used by
// both the transmitter and the receiver, plus the transmitter state encoding.
package trivius_pkg;

  localparam int MIDI_DIV        = 95;  // 48 MHz / (95+1) = 500 kHz tick
  localparam int MIDI_OVERSAMPLE = 16;  // ticks per bit -> 31250 baud
  localparam int MIDI_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } midi_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; clearing the count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/midi_tx.sv
// MIDI 8N1 serial transmitter: valid/ready byte input, small FIFO, and a
// tick-divided bit timer shared in structure with the MIDI receiver.
module midi_tx
  import trivius_pkg::*;
#(
  parameter int DIV        = MIDI_DIV,
  parameter int OVERSAMPLE = MIDI_OVERSAMPLE,
  parameter int FIFO_DEPTH = MIDI_FIFO_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int TICK_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int OS_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);

  midi_tx_state_t    state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          tick_pulse, bit_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    tick_pulse = (tick_q == TICK_LAST);
    bit_end    = tick_pulse && (os_q == OS_LAST);

    // Bit timing only advances while a frame is on the line.
    if (state_q != IDLE) begin
      tick_d = tick_pulse ? '0 : tick_q + TICK_W'(1);
      if (tick_pulse) os_d = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
    end

    case (state_q)
      IDLE: tx_d = 1'b1;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Loading the next byte restarts the bit timer, so frames stay exactly
    // ten bit periods long and back-to-back frames have no idle gap.
    if (!fifo_empty && (state_q == IDLE || (state_q == STOP && bit_end))) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      tick_d   = '0;
      os_d     = '0;
      bit_d    = '0;
      state_d  = START;
      tx_d     = 1'b0;
    end

    busy_d = (state_d != IDLE) || (fifo_count != '0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready = !fifo_full;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_midi_tx.sv
// Scoreboard bench for midi_tx: the driver queues expected bytes on each
// accepted handshake, a line monitor decodes 8N1 frames and compares in order.
module tb_midi_tx;

  localparam int DIV   = 3;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int BIT   = OS * (DIV + 1);
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_tx, o_busy;

  midi_tx #(
    .DIV        (DIV),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_tx      (o_tx),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_started = 0;
  int         last_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_mon(input int n, output logic ab);
    ab = 1'b0;
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // Line monitor: detect start edge, sample each bit mid-period, score the byte.
  initial begin : monitor
    logic       prev_tx;
    logic       aborted;
    logic [7:0] data;
    prev_tx = 1'b1;
    data    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx && !o_tx) begin
        frames_started++;
        last_start = cyc;
        start_q.push_back(cyc);
        wait_mon(BIT / 2, aborted);
        if (!aborted) check("start_bit", 32'(o_tx), 32'd0);
        for (int i = 0; i < 8 && !aborted; i++) begin
          wait_mon(BIT, aborted);
          data[i] = o_tx;
        end
        if (!aborted) wait_mon(BIT, aborted);
        if (!aborted) begin
          check("stop_bit", 32'(o_tx), 32'd1);
          check("sb_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("sb_byte", 32'(data), 32'(exp_q.pop_front()));
        end
        while (!rst_n) @(negedge clk);
      end
      prev_tx = o_tx;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input logic [7:0] b, output int acc);
    int n = 0;
    i_valid = 1'b1;
    while (!o_ready && n < 2 * FRAME) begin
      i_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    check("offer_ready", 32'(o_ready), 32'd1);
    i_data = b;
    acc = cyc + 1;
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound, output int fall);
    int n = 0;
    while (o_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(o_busy), 32'd0);
    fall = cyc;
  endtask

  initial begin : watchdog
    #(1_000_000);
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         acc[8];
    int         fall, f0, dummy;
    logic [7:0] ovf[8];
    ovf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hFF, 8'h00};

    // Reset held with a byte offered: nothing may be accepted or sent.
    i_valid = 1'b1;
    i_data  = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      check("rst_tx", 32'(o_tx), 32'd1);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
    end
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME / 2) @(negedge clk);
    check("rst_no_frame", 32'(frames_started), 32'd0);
    check("rst_busy_after", 32'(o_busy), 32'd0);

    // Single byte: latency, busy window.
    offer(8'h90, acc[0]);
    i_valid = 1'b0;
    check("lat_tx_at_k", 32'(o_tx), 32'd1);
    check("lat_busy_at_k", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("lat_tx_at_k1", 32'(o_tx), 32'd0);
    check("lat_busy_at_k1", 32'(o_busy), 32'd1);
    wait_idle(2 * FRAME, fall);
    check("single_tx_fall", 32'(last_start), 32'(acc[0] + 1));
    check("single_busy_len", 32'(fall - last_start), 32'(FRAME));
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Burst of three on consecutive cycles: contiguous frames.
    start_q.delete();
    offer(8'h90, dummy);
    offer(8'h3C, dummy);
    offer(8'h7F, dummy);
    i_valid = 1'b0;
    wait_idle(4 * FRAME, fall);
    check("burst_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("burst_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME));
      check("burst_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME));
      check("burst_total", 32'(fall - start_q[0]), 32'(3 * FRAME));
    end
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: valid held for 8 bytes; data scrambled while not ready.
    for (int i = 0; i < 8; i++) offer(ovf[i], acc[i]);
    i_valid = 1'b0;
    for (int i = 1; i < 5; i++) check($sformatf("ovf_acc%0d", i), 32'(acc[i] - acc[0]), 32'(i));
    check("ovf_acc5", 32'(acc[5] - acc[0]), 32'(FRAME + 2));
    check("ovf_acc6", 32'(acc[6] - acc[0]), 32'(2 * FRAME + 2));
    check("ovf_acc7", 32'(acc[7] - acc[0]), 32'(3 * FRAME + 2));
    wait_idle(10 * FRAME, fall);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Reset during bit 3 of 0x55 with two bytes queued.
    offer(8'h55, acc[0]);
    offer(8'hA1, dummy);
    offer(8'hB2, dummy);
    i_valid = 1'b0;
    while (cyc < acc[0] + 1 + 4 * BIT + BIT / 2) @(negedge clk);
    check("mid_bit3", 32'(o_tx), 32'd0);
    f0 = frames_started;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(o_tx), 32'd1);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    check("mid_no_frame", 32'(frames_started), 32'(f0));
    check("mid_busy_after", 32'(o_busy), 32'd0);
    check("mid_tx_after", 32'(o_tx), 32'd1);

    // Loopback-style stream of random bytes through the decoding monitor.
    for (int i = 0; i < 24; i++) offer(8'($urandom), dummy);
    i_valid = 1'b0;
    wait_idle(30 * FRAME, fall);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
